// File: rtl/vga_pkg.sv
// Shared constants, pattern encodings and colours for the VGA pixel stage.
// Also holds the compare-based colour-bar index helper.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int BAR_WIDTH = 80;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'b00,
    MODE_CHECK = 2'b01,
    MODE_BOX   = 2'b10,
    MODE_GRAD  = 2'b11
  } mode_e;

  localparam logic [11:0] COL_BOX   = 12'hF80;
  localparam logic [11:0] COL_BG    = 12'h004;
  localparam logic [11:0] COL_WHITE = 12'hFFF;
  localparam logic [11:0] COL_BLACK = 12'h000;

  // Bar number from a chain of constant compares, avoiding a divide-by-80.
  function automatic logic [2:0] bar_index(input logic [9:0] px);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (px >= 10'(k * BAR_WIDTH)) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/box_mover.sv
// One axis of the bouncing box: steps by SPEED on each strobe, saturating and
// reversing at 0 and LIMIT-SIZE. Position updates the edge after step_i.
module box_mover #(
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int SPEED = 2,
  parameter int INIT  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_i,
  output logic [9:0] pos_o,
  output logic       dir_o
);

  localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
  localparam logic [9:0]  SPD     = 10'(SPEED);

  logic [9:0]  pos_q, pos_d;
  logic        dir_q, dir_d;
  logic [10:0] fwd;

  // dir_q = 0 moves towards higher coordinates, 1 towards zero.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    fwd   = {1'b0, pos_q} + 11'(SPEED);
    if (step_i) begin
      if (!dir_q) begin
        if (fwd > MAX_POS) begin
          pos_d = MAX_POS[9:0];
          dir_d = 1'b1;
        end else begin
          pos_d = fwd[9:0];
        end
      end else begin
        if (pos_q < SPD) begin
          pos_d = 10'd0;
          dir_d = 1'b0;
        end else begin
          pos_d = pos_q - SPD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= 10'(INIT);
      dir_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// 640x480 pattern generator: bars, checker, bouncing box, gradient; no backpressure.
// RGB and syncs leave 2 clk after the counters; mode/box change only at frame_tick.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int BOX_SIZE  = 32,
  parameter int BOX_SPEED = 2,
  parameter int BOX_X0    = 100,
  parameter int BOX_Y0    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] mode,
  input  logic       freeze,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  logic [9:0]  x_q, y_q;
  logic        von_q;
  logic        hs_q, vs_q;
  logic [11:0] rgb_q, rgb_d;
  logic        ft_q, ft_d;
  mode_e       mode_q;

  logic [9:0]  box_x, box_y;
  logic        dir_x, dir_y;
  logic        box_step;
  logic [2:0]  bar_c;
  logic        in_box;
  logic [11:0] col;

  assign box_step = ft_q & ~freeze;
  assign ft_d     = (x == 10'd0) && (y == 10'(V_VISIBLE));

  box_mover #(
    .LIMIT(H_VISIBLE), .SIZE(BOX_SIZE), .SPEED(BOX_SPEED), .INIT(BOX_X0)
  ) u_box_x (
    .clk(clk), .rst(rst), .step_i(box_step), .pos_o(box_x), .dir_o(dir_x)
  );

  box_mover #(
    .LIMIT(V_VISIBLE), .SIZE(BOX_SIZE), .SPEED(BOX_SPEED), .INIT(BOX_Y0)
  ) u_box_y (
    .clk(clk), .rst(rst), .step_i(box_step), .pos_o(box_y), .dir_o(dir_y)
  );

  always_comb begin
    col    = COL_BLACK;
    bar_c  = 3'd7 - bar_index(x_q);
    in_box = ({1'b0, x_q} >= {1'b0, box_x}) &&
             ({1'b0, x_q} <  ({1'b0, box_x} + 11'(BOX_SIZE))) &&
             ({1'b0, y_q} >= {1'b0, box_y}) &&
             ({1'b0, y_q} <  ({1'b0, box_y} + 11'(BOX_SIZE)));
    case (mode_q)
      MODE_BARS:  col = {{4{bar_c[1]}}, {4{bar_c[2]}}, {4{bar_c[0]}}};
      MODE_CHECK: col = (x_q[5] ^ y_q[5]) ? COL_WHITE : COL_BLACK;
      MODE_BOX:   col = in_box ? COL_BOX : COL_BG;
      MODE_GRAD:  col = {x_q[9:6], y_q[8:5], x_q[5:2] ^ y_q[5:2]};
      default:    col = COL_BLACK;
    endcase
    rgb_d = von_q ? col : COL_BLACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      von_q  <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      rgb_q  <= '0;
      ft_q   <= 1'b0;
      mode_q <= MODE_BARS;
    end else begin
      x_q   <= x;
      y_q   <= y;
      von_q <= video_on;
      // Syncs already trail x/y by one clk, so a single stage lines them up with RGB.
      hs_q  <= hsync_in;
      vs_q  <= vsync_in;
      rgb_q <= rgb_d;
      ft_q  <= ft_d;
      if (ft_q) mode_q <= mode_e'(mode);
    end
  end

  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: bench-side sync stage, per-cycle pixel model, literal pins.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst, hsync_in, vsync_in, video_on, freeze;
  logic [9:0] x, y;
  logic [1:0] mode;
  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, ft0, hs1, vs1, ft1;

  vga_pattern_gen dut0 (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on(video_on),
    .x(x), .y(y), .mode(mode), .freeze(freeze),
    .red(r0), .green(g0), .blue(b0), .hsync(hs0), .vsync(vs0), .frame_tick(ft0)
  );

  // Second box start chosen so both axes reach their far wall on the same frame.
  vga_pattern_gen #(.BOX_X0(161), .BOX_Y0(1)) dut1 (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on(video_on),
    .x(x), .y(y), .mode(mode), .freeze(freeze),
    .red(r1), .green(g1), .blue(b1), .hsync(hs1), .vsync(vs1), .frame_tick(ft1)
  );

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int nprint = 0;

  int hx_prev = 0;
  int vy_prev = 0;

  int         X0 [2] = '{100, 161};
  int         Y0 [2] = '{60, 1};
  int         m_bx [2], m_by [2];
  bit         m_dx [2], m_dy [2];
  int         m_mode;
  bit         m_ft;
  bit         m_run = 1'b0;
  bit         s_valid = 1'b0;
  int         p_x, p_y, s_x, s_y;
  bit         p_von = 1'b0;
  logic [14:0] m_exp [2];

  logic [11:0] seen0 [int];
  logic [11:0] seen1 [int];
  logic        seen_hs0 [int];

  function automatic int key(input int px, input int py);
    return py * 1024 + px;
  endfunction

  function automatic logic [11:0] colour(input int px, input int py, input int md,
                                         input int bx, input int by);
    int c, r, g, b;
    case (md)
      0: begin
        c = 7 - px / 80;
        r = (c / 2) % 2;
        g = c / 4;
        b = c % 2;
        return 12'(r * 15 * 256 + g * 15 * 16 + b * 15);
      end
      1: return (((px / 32) + (py / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: return (px >= bx && px < bx + 32 && py >= by && py < by + 32) ? 12'hF80 : 12'h004;
      default: begin
        r = px / 64;
        g = (py / 32) % 16;
        b = ((px / 4) % 16) ^ ((py / 4) % 16);
        return 12'(r * 256 + g * 16 + b);
      end
    endcase
  endfunction

  function automatic void mstep(input int pos_i, input bit neg_i, input int lim,
                                output int pos_o, output bit neg_o);
    pos_o = pos_i;
    neg_o = neg_i;
    if (!neg_i) begin
      if (pos_i + 2 > lim - 32) begin pos_o = lim - 32; neg_o = 1'b1; end
      else pos_o = pos_i + 2;
    end else begin
      if (pos_i < 2) begin pos_o = 0; neg_o = 1'b0; end
      else pos_o = pos_i - 2;
    end
  endfunction

  // Model: what each output slot must show, from the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_bx[k] = X0[k]; m_by[k] = Y0[k]; m_dx[k] = 1'b0; m_dy[k] = 1'b0;
        m_exp[k] = {12'h000, 3'b110};
      end
      m_mode = 0;
      m_ft = 1'b0;
      s_valid = 1'b0;
      p_von = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++)
        m_exp[k] = {p_von ? colour(p_x, p_y, m_mode, m_bx[k], m_by[k]) : 12'h000,
                    hsync_in, vsync_in, (x == 10'd0 && y == 10'd480)};
      s_x = p_x; s_y = p_y; s_valid = 1'b1;
      if (m_ft) begin
        m_mode = int'(mode);
        if (!freeze)
          for (int k = 0; k < 2; k++) begin
            mstep(m_bx[k], m_dx[k], 640, m_bx[k], m_dx[k]);
            mstep(m_by[k], m_dy[k], 480, m_by[k], m_dy[k]);
          end
      end
      m_ft = (x == 10'd0 && y == 10'd480);
      p_von = video_on;
    end
    p_x = int'(x);
    p_y = int'(y);
    m_run = 1'b1;
  end

  always @(negedge clk) begin
    if (m_run) begin
      total++;
      if ({r0, g0, b0, hs0, vs0, ft0} !== m_exp[0]) begin
        bad++;
        if (nprint < 30) $display("FAIL model0 at pixel (%0d,%0d): got %h want %h",
                                  s_x, s_y, {r0, g0, b0, hs0, vs0, ft0}, m_exp[0]);
        nprint++;
      end
      total++;
      if ({r1, g1, b1, hs1, vs1, ft1} !== m_exp[1]) begin
        bad++;
        if (nprint < 30) $display("FAIL model1 at pixel (%0d,%0d): got %h want %h",
                                  s_x, s_y, {r1, g1, b1, hs1, vs1, ft1}, m_exp[1]);
        nprint++;
      end
      if (s_valid) begin
        seen0[key(s_x, s_y)]    = {r0, g0, b0};
        seen1[key(s_x, s_y)]    = {r1, g1, b1};
        seen_hs0[key(s_x, s_y)] = hs0;
      end
      if (ft0) tick_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk0(input string nm, input int px, input int py, input logic [11:0] exp);
    chk(nm, {20'd0, seen0[key(px, py)]}, {20'd0, exp});
  endtask

  task automatic chk1(input string nm, input int px, input int py, input logic [11:0] exp);
    chk(nm, {20'd0, seen1[key(px, py)]}, {20'd0, exp});
  endtask

  // Sync stage stand-in: syncs are registered, so they reflect the previous x/y.
  task automatic emit(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    video_on = (px < 640) && (py < 480);
    hsync_in = !(hx_prev >= 656 && hx_prev < 752);
    vsync_in = !(vy_prev >= 490 && vy_prev < 492);
    hx_prev = px;
    vy_prev = py;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int px, input int py, input int n);
    int cx = px;
    int cy = py;
    for (int i = 0; i < n; i++) begin
      emit(cx, cy);
      cx++;
      if (cx == 800) begin
        cx = 0;
        cy++;
        if (cy == 525) cy = 0;
      end
    end
  endtask

  task automatic flush();
    emit(700, 500);
    emit(700, 500);
  endtask

  task automatic tick();
    run(798, 479, 4);
  endtask

  task automatic probe_box(input int k);
    int bx = m_bx[k];
    int by = m_by[k];
    emit(bx, by);
    if (bx > 0) emit(bx - 1, by);
    emit(bx + 31, by + 31);
    if (bx + 32 < 640) emit(bx + 32, by + 31);
    if (by > 0) emit(bx, by - 1);
    if (by + 32 < 480) emit(bx, by + 32);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'b00; freeze = 1'b0;
    x = '0; y = '0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      emit(300 + i, 5);
      @(negedge clk);
      chk("rst_rgb", {20'd0, r0, g0, b0}, 32'h0);
      chk("rst_sync", {29'd0, hs0, vs0, ft0}, 32'h6);
    end
    rst = 1'b0;

    run(0, 10, 803);
    chk0("bar_x0", 0, 10, 12'hFFF);
    chk0("bar_x79", 79, 10, 12'hFFF);
    chk0("bar_x80", 80, 10, 12'hFF0);
    chk0("bar_x200", 200, 10, 12'h0FF);
    chk0("bar_x560", 560, 10, 12'h000);
    chk0("bar_x639", 639, 10, 12'h000);
    chk0("blank_x640", 640, 10, 12'h000);
    chk("hs_655", {31'd0, seen_hs0[key(655, 10)]}, 32'd1);
    chk("hs_656", {31'd0, seen_hs0[key(656, 10)]}, 32'd0);
    chk("hs_752", {31'd0, seen_hs0[key(752, 10)]}, 32'd1);

    mode = 2'b10; freeze = 1'b1;
    tick(); probe_box(0); probe_box(1); flush();
    chk0("box0_init_in", 100, 60, 12'hF80);
    chk0("box0_init_left", 99, 60, 12'h004);
    chk0("box0_init_br", 131, 91, 12'hF80);
    chk0("box0_init_out", 132, 91, 12'h004);
    chk1("box1_init_in", 161, 1, 12'hF80);
    chk1("box1_init_left", 160, 1, 12'h004);

    freeze = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      tick(); probe_box(0); probe_box(1); flush();
      case (n)
        1:   begin chk0("box_f1_in", 102, 62, 12'hF80); chk0("box_f1_out", 101, 62, 12'h004); end
        20:  begin chk0("box_f20_in", 140, 100, 12'hF80); chk0("box_f20_out", 139, 100, 12'h004); end
        223: chk1("corner_f223", 607, 447, 12'hF80);
        224: begin chk1("corner_f224_in", 608, 448, 12'hF80); chk1("corner_f224_out", 607, 448, 12'h004); end
        225: begin chk1("corner_f225_in", 606, 446, 12'hF80); chk1("corner_f225_out", 605, 446, 12'h004); end
        253: chk0("box_f253", 606, 332, 12'hF80);
        254: begin chk0("box_f254_in", 608, 330, 12'hF80); chk0("box_f254_out", 607, 330, 12'h004); end
        256: begin chk0("box_f256_in", 606, 326, 12'hF80); chk0("box_f256_out", 605, 326, 12'h004); end
        default: ;
      endcase
    end

    freeze = 1'b1;
    tick(); probe_box(0); flush();
    chk0("freeze_hold", 606, 326, 12'hF80);
    chk0("freeze_hold_out", 605, 326, 12'h004);
    freeze = 1'b0;

    mode = 2'b00;
    tick();
    run(0, 200, 4);
    mode = 2'b01;
    run(4, 200, 4);
    emit(32, 300); emit(33, 300); flush();
    chk0("mode_midframe_hold", 32, 300, 12'hFFF);
    tick();
    emit(32, 0); emit(0, 0); emit(32, 32); flush();
    chk0("check_32_0", 32, 0, 12'hFFF);
    chk0("check_0_0", 0, 0, 12'h000);
    chk0("check_32_32", 32, 32, 12'h000);

    mode = 2'b11;
    tick_cnt = 0;
    run(790, 478, 2420);
    chk("tick_once", 32'(tick_cnt), 32'd1);
    emit(100, 50); emit(65, 37); flush();
    chk0("grad_100_50", 100, 50, 12'h115);
    chk0("grad_65_37", 65, 37, 12'h119);

    rst = 1'b1;
    emit(400, 300); emit(401, 300);
    rst = 1'b0;
    emit(0, 10); flush();
    chk0("rst_mode_bars", 0, 10, 12'hFFF);
    mode = 2'b10; freeze = 1'b1;
    tick(); probe_box(0); probe_box(1); flush();
    chk0("rst_box0", 100, 60, 12'hF80);
    chk0("rst_box0_out", 99, 60, 12'h004);
    chk1("rst_box1", 161, 1, 12'hF80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
